// File: rtl/cla_adder.sv
// cla_adder: two-level carry-lookahead adder with registered sum and carry-out.
// Define CLA_ADDER_IN_REG_EN to register A/B/C_in first (latency 2 instead of 1).
module cla_adder #(
    parameter int Width = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [Width-1:0] A,
    input  logic [Width-1:0] B,
    input  logic             C_in,
    output logic [Width-1:0] S,
    output logic             C_out
);
    localparam int NG = (Width + 3) / 4;
    localparam int NB = (NG + 3) / 4;

    // Flattened sum-of-products carry into position n of a 4-wide (g,p) group.
    function automatic logic lookahead(input logic [3:0] g, input logic [3:0] p, input logic ci, input int n);
        logic r, t;
        r = 1'b0;
        for (int j = 0; j < 4; j++) begin
            if (j < n) begin
                t = g[j];
                for (int m = 0; m < 4; m++) if (m > j && m < n) t = t & p[m];
                r = r | t;
            end
        end
        t = ci;
        for (int m = 0; m < 4; m++) if (m < n) t = t & p[m];
        return r | t;
    endfunction

    logic [Width-1:0] a_w, b_w;
    logic             ci_w;

`ifdef CLA_ADDER_IN_REG_EN
    logic [Width-1:0] a_q, b_q;
    logic             ci_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q  <= '0;
            b_q  <= '0;
            ci_q <= 1'b0;
        end else begin
            a_q  <= A;
            b_q  <= B;
            ci_q <= C_in;
        end
    end

    assign a_w  = a_q;
    assign b_w  = b_q;
    assign ci_w = ci_q;
`else
    assign a_w  = A;
    assign b_w  = B;
    assign ci_w = C_in;
`endif

    logic [Width-1:0] s_d, s_q;
    logic             co_d, co_q;

    always_comb begin : lookahead_net
        logic [4*NG-1:0] gp, pp;
        logic [4*NB-1:0] gg, pg;
        logic [NG-1:0]   gc;
        logic [NB-1:0]   bc;
        logic [Width:0]  cc;
        gp = '0;
        pp = '0;
        gg = '0;
        pg = '0;
        gc = '0;
        bc = '0;
        cc = '0;
        gp[Width-1:0] = a_w & b_w;
        pp[Width-1:0] = a_w ^ b_w;
        for (int k = 0; k < NG; k++) begin
            gg[k] = lookahead(gp[4*k +: 4], pp[4*k +: 4], 1'b0, 4);
            pg[k] = &pp[4*k +: 4];
        end
        // Padded groups/blocks carry g=p=0, so they never disturb real carries.
        bc[0] = ci_w;
        for (int b = 0; b < NB; b++) begin
            for (int i = 0; i < 4; i++)
                if (4*b + i < NG) gc[4*b+i] = lookahead(gg[4*b +: 4], pg[4*b +: 4], bc[b], i);
            if (b + 1 < NB) bc[b+1] = lookahead(gg[4*b +: 4], pg[4*b +: 4], bc[b], 4);
        end
        for (int k = 0; k < NG; k++) begin
            cc[4*k] = gc[k];
            for (int i = 1; i < 5; i++)
                if ((i < 4 || k == NG - 1) && 4*k + i <= Width)
                    cc[4*k+i] = lookahead(gp[4*k +: 4], pp[4*k +: 4], gc[k], i);
        end
        s_d  = pp[Width-1:0] ^ cc[Width-1:0];
        co_d = cc[Width];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q  <= '0;
            co_q <= 1'b0;
        end else begin
            s_q  <= s_d;
            co_q <= co_d;
        end
    end

    assign S     = s_q;
    assign C_out = co_q;
endmodule

// File: tb/tb_cla_adder.sv
// tb_cla_adder: directed table plus hand sequences for cla_adder at Width 8, 13, 20 and 1.
module tb_cla_adder;
`ifdef CLA_ADDER_IN_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  a8 = '0, b8 = '0, s8;
    logic        c8 = 1'b0, co8;
    logic [12:0] a13 = '0, b13 = '0, s13;
    logic        c13 = 1'b0, co13;
    logic [19:0] a20 = '0, b20 = '0, s20;
    logic        c20 = 1'b0, co20;
    logic [0:0]  a1 = '0, b1 = '0, s1;
    logic        c1 = 1'b0, co1;

    cla_adder #(.Width(8))  u8  (.clk(clk), .rst_n(rst_n), .A(a8),  .B(b8),  .C_in(c8),  .S(s8),  .C_out(co8));
    cla_adder #(.Width(13)) u13 (.clk(clk), .rst_n(rst_n), .A(a13), .B(b13), .C_in(c13), .S(s13), .C_out(co13));
    cla_adder #(.Width(20)) u20 (.clk(clk), .rst_n(rst_n), .A(a20), .B(b20), .C_in(c20), .S(s20), .C_out(co20));
    cla_adder #(.Width(1))  u1  (.clk(clk), .rst_n(rst_n), .A(a1),  .B(b1),  .C_in(c1),  .S(s1),  .C_out(co1));

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [8:0] exp;
    } vec_t;

    int tests = 0;
    int fails = 0;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    vec_t tv[8];
    logic [8:0] hist[100];

    initial begin
        tv[0] = '{8'hFF, 8'h01, 1'b0, 9'h100};
        tv[1] = '{8'h7F, 8'h80, 1'b1, 9'h100};
        tv[2] = '{8'h55, 8'hAA, 1'b0, 9'h0FF};
        tv[3] = '{8'h00, 8'h00, 1'b1, 9'h001};
        tv[4] = '{8'hFF, 8'hFF, 1'b1, 9'h1FF};
        tv[5] = '{8'h0F, 8'h01, 1'b0, 9'h010};
        tv[6] = '{8'hF0, 8'h10, 1'b0, 9'h100};
        tv[7] = '{8'h3C, 8'h5A, 1'b1, 9'h097};

        tick(2);
        chk("reset8",  {co8, s8},   32'h0);
        chk("reset13", {co13, s13}, 32'h0);
        chk("reset20", {co20, s20}, 32'h0);
        chk("reset1",  {co1, s1},   32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            a8 = tv[i].a;
            b8 = tv[i].b;
            c8 = tv[i].ci;
            tick(LAT);
            chk($sformatf("vec%0d", i), {23'h0, co8, s8}, {23'h0, tv[i].exp});
        end

        rst_n = 1'b0;
        a8 = 8'h12;
        b8 = 8'h34;
        c8 = 1'b0;
        tick(1);
        chk("rst_edge1", {co8, s8}, 32'h0);
        tick(1);
        chk("rst_edge2", {co8, s8}, 32'h0);
        rst_n = 1'b1;
        tick(LAT);
        chk("rst_release", {co8, s8}, 32'h046);

        for (int i = 0; i < 100; i++) begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            c8 = 1'((i / 5) % 2);
            hist[i] = 9'(a8) + 9'(b8) + 9'(c8);
            tick(1);
            if (i >= LAT - 1) chk($sformatf("stream%0d", i), {co8, s8}, {23'h0, hist[i-LAT+1]});
        end

        a8 = 8'hFF;
        b8 = 8'hFF;
        rst_n = 1'b0;
        tick(1);
        chk("midrst", {co8, s8}, 32'h0);
        rst_n = 1'b1;
        a8 = 8'h01;
        b8 = 8'h02;
        c8 = 1'b0;
        tick(LAT);
        chk("post_midrst", {co8, s8}, 32'h003);

        a13 = 13'h1FFF; b13 = 13'h0; c13 = 1'b1;
        a20 = 20'hFFFFF; b20 = 20'h0; c20 = 1'b1;
        tick(LAT);
        chk("w13_ones", {co13, s13}, 32'h2000);
        chk("w20_ones", {co20, s20}, 32'h100000);
        a13 = 13'h1000; b13 = 13'h1000; c13 = 1'b0;
        a20 = 20'h80000; b20 = 20'h80000; c20 = 1'b0;
        tick(LAT);
        chk("w13_msb", {co13, s13}, 32'h2000);
        chk("w20_msb", {co20, s20}, 32'h100000);
        a13 = 13'h0ABC; b13 = 13'h0F0F; c13 = 1'b1;
        a20 = 20'h12345; b20 = 20'h0FFFF; c20 = 1'b0;
        tick(LAT);
        chk("w13_mix", {co13, s13}, 32'h19CC);
        chk("w20_mix", {co20, s20}, 32'h22344);

        for (int i = 0; i < 8; i++) begin
            a1 = 1'(i >> 2);
            b1 = 1'(i >> 1);
            c1 = 1'(i);
            tick(LAT);
            chk($sformatf("w1_%0d", i), {co1, s1},
                {30'h0, (a1[0] & b1[0]) | (a1[0] & c1) | (b1[0] & c1), a1[0] ^ b1[0] ^ c1});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
